// File: rtl/demux_pkg.sv
// Shared constants, state encoding and select decode for the round-robin demux dispatcher.
package demux_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic logic [NCH-1:0] onehot8(input logic [SEL_W-1:0] s);
    logic [NCH-1:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux_rr_dispatcher_rr_pick8.sv
// Circular first-set search over an 8-bit mask, beginning at index start and wrapping.
module rr_pick8
  import demux_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset back to the nearest so the nearest hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      cand = start + SEL_W'(k);
      if (mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// One-entry stream register that steers each accepted word to one of eight channels,
// picked round-robin over an enable mask or fixed by configuration.
module demux_rr_dispatcher
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NCH-1:0]     ch_en,
  input  logic               cfg_mode,
  input  logic [SEL_W-1:0]   cfg_sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [NCH-1:0]     out_valid,
  input  logic [NCH-1:0]     out_ready,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic [CNT_W-1:0]   xfer_cnt
);

  // Handshake: a word moves on in_valid & in_ready (upstream) and on out_valid[i] & out_ready[i]
  // (downstream); in_ready never depends on in_valid, and out_valid holds until delivery.

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NCH-1:0]     pick_mask;
  logic [SEL_W-1:0]   idx_head, idx_next;
  logic               found_head, found_next;
  logic               deliver;
  logic               accept;

  // Fixed mode reduces the mask to the single configured channel, so both pickers
  // yield cfg_sel exactly when that channel is enabled.
  assign pick_mask = cfg_mode ? (ch_en & onehot8(cfg_sel)) : ch_en;

  rr_pick8 u_pick_head (
    .mask  (pick_mask),
    .start (ptr_q),
    .idx   (idx_head),
    .found (found_head)
  );

  rr_pick8 u_pick_next (
    .mask  (pick_mask),
    .start (sel_q + SEL_W'(1)),
    .idx   (idx_next),
    .found (found_next)
  );

  assign deliver = (state_q == ST_FULL) & out_ready[sel_q];
  assign accept  = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_FULL;
          sel_d   = idx_head;
          data_d  = in_data;
        end
      end
      ST_FULL: begin
        if (deliver) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!cfg_mode) ptr_d = sel_q + SEL_W'(1);
          // Accept in FULL implies delivery, since in_ready requires out_ready[sel_q].
          if (accept) begin
            sel_d  = idx_next;
            data_d = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = (state_q == ST_FULL);
    out_valid = busy ? onehot8(sel_q) : '0;
    if (!rst) begin
      case (state_q)
        ST_EMPTY: in_ready = found_head;
        ST_FULL:  in_ready = out_ready[sel_q] & found_next;
        default:  in_ready = 1'b0;
      endcase
    end
  end

  assign out_data = data_q;
  assign sel      = sel_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Bench for demux_rr_dispatcher: table vectors, directed corner sequences and a random run
// against a queue-based reference model of the dispatch rules.
module tb_demux_rr_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  ch_en;
  logic        cfg_mode;
  logic [2:0]  cfg_sel;
  logic [7:0]  out_data;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [2:0]  sel;
  logic        busy;
  logic [15:0] xfer_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: the held word is a queue of at most one {target, data} entry.
  int         m_tgt_q[$];
  logic [7:0] m_dat_q[$];
  int         m_ptr;
  int         m_total;
  logic [7:0] m_last_data;

  logic [7:0] exp_q[$];

  demux_rr_dispatcher #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ch_en     (ch_en),
    .cfg_mode  (cfg_mode),
    .cfg_sel   (cfg_sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_pick(input int start, output bit f, output int idx);
    f = 1'b0;
    idx = 0;
    if (cfg_mode) begin
      f = ch_en[cfg_sel];
      idx = int'(cfg_sel);
    end else begin
      for (int k = 7; k >= 0; k--) begin
        if (ch_en[(start + k) % 8]) begin
          f = 1'b1;
          idx = (start + k) % 8;
        end
      end
    end
  endfunction

  function automatic bit m_in_ready();
    bit f;
    int idx;
    if (rst) return 1'b0;
    if (m_tgt_q.size() == 0) begin
      m_pick(m_ptr, f, idx);
      return f;
    end
    m_pick((m_tgt_q[0] + 1) % 8, f, idx);
    return out_ready[m_tgt_q[0]] && f;
  endfunction

  function automatic void m_reset();
    m_tgt_q.delete();
    m_dat_q.delete();
    m_ptr = 0;
    m_total = 0;
    m_last_data = 8'h00;
  endfunction

  // One clock: compare everything at the falling edge, advance the model, return just after rise.
  task automatic cycle();
    bit   rdy, f, dlv;
    int   idx, start;
    logic [7:0] ev;
    @(negedge clk);
    rdy = m_in_ready();
    ev = (m_tgt_q.size() != 0) ? (8'h01 << m_tgt_q[0]) : 8'h00;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("busy", 32'(busy), 32'(m_tgt_q.size() != 0));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(m_total % 65536));
    chk("out_data", 32'(out_data), 32'(m_last_data));
    if (m_tgt_q.size() != 0) chk("sel", 32'(sel), 32'(m_tgt_q[0]));
    dlv = (m_tgt_q.size() != 0) && out_ready[m_tgt_q[0]];
    start = (m_tgt_q.size() != 0) ? (m_tgt_q[0] + 1) % 8 : m_ptr;
    m_pick(start, f, idx);
    if (dlv) begin
      m_total++;
      if (!cfg_mode) m_ptr = (m_tgt_q[0] + 1) % 8;
      void'(m_tgt_q.pop_front());
      void'(m_dat_q.pop_front());
    end
    if (in_valid && rdy) begin
      m_tgt_q.push_back(idx);
      m_dat_q.push_back(in_data);
      m_last_data = in_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit         mode;
    logic [2:0] csel;
    logic [7:0] en;
    bit         exp_found;
    logic [2:0] exp_idx;
  } vec_t;

  vec_t vecs[8];

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; ch_en = '0;
    cfg_mode = 1'b0; cfg_sel = '0; out_ready = '0;

    // Single-word picks from ptr=0, expectations worked out by hand.
    vecs[0] = '{1'b0, 3'd0, 8'hFF, 1'b1, 3'd0};
    vecs[1] = '{1'b0, 3'd0, 8'h80, 1'b1, 3'd7};
    vecs[2] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0};
    vecs[3] = '{1'b0, 3'd6, 8'h30, 1'b1, 3'd4};
    vecs[4] = '{1'b1, 3'd5, 8'h20, 1'b1, 3'd5};
    vecs[5] = '{1'b1, 3'd5, 8'hDF, 1'b0, 3'd0};
    vecs[6] = '{1'b1, 3'd0, 8'h01, 1'b1, 3'd0};
    vecs[7] = '{1'b1, 3'd3, 8'hFF, 1'b1, 3'd3};

    #2;
    do_reset();

    for (int v = 0; v < 8; v++) begin
      do_reset();
      cfg_mode = vecs[v].mode; cfg_sel = vecs[v].csel; ch_en = vecs[v].en;
      out_ready = 8'h00; in_valid = 1'b1; in_data = 8'(8'h40 + v);
      #1;
      chk("vec_found", 32'(in_ready), 32'(vecs[v].exp_found));
      cycle();
      in_valid = 1'b0;
      chk("vec_busy", 32'(busy), 32'(vecs[v].exp_found));
      if (vecs[v].exp_found) chk("vec_sel", 32'(sel), 32'(vecs[v].exp_idx));
      out_ready = 8'hFF;
      cycle();
    end

    // Round-robin over a full mask, one word per cycle.
    do_reset();
    cfg_mode = 1'b0; ch_en = 8'hFF; out_ready = 8'hFF;
    for (int i = 0; i < 10; i++) exp_q.push_back(8'h01 << (i % 8));
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 10); in_data = 8'(i + 1);
      cycle();
      if (busy) begin
        if (exp_q.size() == 0) chk("rr_extra_word", 32'(out_valid), 32'h0);
        else chk("rr_out_valid", 32'(out_valid), 32'(exp_q.pop_front()));
      end
    end
    chk("rr_all_seen", 32'(exp_q.size()), 32'h0);
    chk("rr_xfer_cnt", 32'(xfer_cnt), 32'd10);

    // Reset while a word is held on channel 2.
    cfg_mode = 1'b0; ch_en = 8'h04; out_ready = 8'h00; in_valid = 1'b1; in_data = 8'hA5;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("pre_rst_out_valid", 32'(out_valid), 32'h04);
    do_reset();
    cycle();

    // Sparse mask: targets alternate 1,7,1,7 with in_ready held high.
    do_reset();
    ch_en = 8'b1000_0010; out_ready = 8'hFF;
    exp_q.push_back(8'd1); exp_q.push_back(8'd7); exp_q.push_back(8'd1); exp_q.push_back(8'd7);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 4); in_data = 8'(8'h70 + i);
      #1;
      if (i < 4) chk("sparse_in_ready", 32'(in_ready), 32'h1);
      cycle();
      if (busy && exp_q.size() != 0) chk("sparse_sel", 32'(sel), 32'(exp_q.pop_front()));
    end
    chk("sparse_all_seen", 32'(exp_q.size()), 32'h0);

    // Backpressure on channel 3 with the mask cleared underneath the held word.
    do_reset();
    ch_en = 8'h08; out_ready = 8'h00; in_valid = 1'b1; in_data = 8'h3C;
    cycle();
    in_data = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) ch_en = 8'h00;
      cycle();
      chk("bp_out_valid", 32'(out_valid), 32'h08);
      chk("bp_out_data", 32'(out_data), 32'h3C);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 8'h08;
    cycle();
    chk("bp_delivered_busy", 32'(busy), 32'h0);
    chk("bp_delivered_cnt", 32'(xfer_cnt), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_stall", 32'(in_ready), 32'h0);
    end
    in_valid = 1'b0;

    // Fixed mode on channel 5, then a mask that excludes it, then ptr must still be 0.
    do_reset();
    cfg_mode = 1'b1; cfg_sel = 3'd5; ch_en = 8'h20; out_ready = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i < 3); in_data = 8'(8'h90 + i);
      cycle();
      if (i < 3) chk("fix_out_valid", 32'(out_valid), 32'h20);
    end
    ch_en = 8'hDF; in_valid = 1'b1;
    #1;
    chk("fix_blocked", 32'(in_ready), 32'h0);
    cycle();
    cfg_mode = 1'b0; ch_en = 8'hFF; out_ready = 8'h00;
    cycle();
    chk("fix_ptr_kept", 32'(sel), 32'h0);
    in_valid = 1'b0; out_ready = 8'hFF;
    cycle();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      ch_en     = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      out_ready = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      cfg_mode  = ($urandom_range(0, 4) == 0);
      cfg_sel   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 399) == 0) do_reset();
      else cycle();
    end

    // Counter wrap after 65536 deliveries.
    do_reset();
    cfg_mode = 1'b0; ch_en = 8'hFF; out_ready = 8'hFF; in_valid = 1'b1;
    for (int i = 0; i < 70000 && m_total < 65536; i++) begin
      in_data = 8'($urandom);
      cycle();
      if (m_total == 65535) chk("wrap_ffff", 32'(xfer_cnt), 32'hFFFF);
    end
    chk("wrap_reached", 32'(m_total), 32'd65536);
    chk("wrap_zero", 32'(xfer_cnt), 32'h0);
    in_valid = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_rr_dispatcher.md
# demux_rr_dispatcher

- Stream dispatcher that sequences a 1-to-8 demultiplexer.
- Accepts words from a single valid/ready source and holds each word in a one-entry register.
- Steers each word to exactly one of 8 destination channels, chosen round-robin over an enable mask or fixed by configuration.
- Sits between a producer and eight consumer lanes; it owns the demux select, so the select never changes while a word is pending.

## Interface
Parameters:
- WIDTH, 8, data word width in bits

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  WIDTH  source word
- in_valid  input  1  source word present
- in_ready  output  1  dispatcher accepts word this cycle
- ch_en  input  8  per-channel enable mask
- cfg_mode  input  1  0 = round-robin, 1 = fixed channel cfg_sel
- cfg_sel  input  3  fixed target channel when cfg_mode=1
- out_data  output  WIDTH  held word, broadcast to all channels
- out_valid  output  8  one-hot; bit i set means the word targets channel i
- out_ready  input  8  per-channel accept
- sel  output  3  target index of the held word
- busy  output  1  word held (state FULL)
- xfer_cnt  output  16  delivered-word count, wraps 0xFFFF→0

## Operation
- States: EMPTY, FULL. Round-robin pointer ptr[2:0].
- Target pick:
  - cfg_mode=0: first set bit of ch_en searching ptr, ptr+1, … mod 8.
  - cfg_mode=1: cfg_sel, valid only if ch_en[cfg_sel]=1.
  - found=0 when no valid target exists.
- EMPTY:
  - in_ready = found.
  - On in_valid & in_ready: latch out_data←in_data and sel←pick, then go FULL.
  - If found=0, in_ready=0 and the word waits upstream; it is never dropped.
- FULL:
  - out_valid = onehot(sel); busy=1.
  - Delivery: out_ready[sel] high. Bits of out_ready for other channels are ignored.
  - On delivery: ptr←sel+1 mod 8 (round-robin mode only; ptr unchanged in fixed mode), xfer_cnt←xfer_cnt+1.
  - Back-to-back: in_ready = out_ready[sel] & found', where found' is the pick with search start sel+1. If a word is accepted in the same cycle, stay FULL with the new data and target. Otherwise go EMPTY.
- Once latched, the held word's target is frozen.
  - Changes to ch_en, cfg_mode or cfg_sel while FULL affect only the next pick.
  - The held word waits on its latched channel even if that channel is disabled.
- out_data holds its last value in EMPTY; consumers qualify it with out_valid.

## Timing
- Reset values: state=EMPTY, ptr=0, sel=0, out_data=0, out_valid=0, busy=0, in_ready=0 while rst is high, xfer_cnt=0.
- Reset mid-transfer discards the held word with no delivery or count.
- Latency: a word accepted at edge N appears on out_valid in the cycle after edge N (1 cycle).
- Throughput: 1 word/cycle sustained when the targeted channel is ready.
- out_valid, sel, out_data, busy and xfer_cnt are registered.
- in_ready is combinational from ch_en, cfg_*, out_ready, state and ptr; there is no combinational path from in_valid.
- out_valid never deasserts without delivery, except on reset.

## Structure
- Package demux_pkg holds:
  - NCH=8, SEL_W=3
  - state encoding ST_EMPTY=1'b0, ST_FULL=1'b1
  - CNT_W=16
- Sub-module rr_pick8 (combinational): inputs mask[7:0], start[2:0]; outputs idx[2:0], found. Instantiated twice: start=ptr, and start=sel+1 for the back-to-back pick.
- One-hot decode of sel, gated by busy, is done in the top level.

## Test plan
- Reset then idle: rst pulse mid-FULL with out_valid=8'h04 → next cycle out_valid=0, busy=0, xfer_cnt=0, sel=0.
- Round-robin full mask: ch_en=8'hFF, all out_ready=1, 10 words streamed → out_valid sequence 01,02,04,…,80,01,02; one word/cycle; xfer_cnt=10.
- Sparse mask: ch_en=8'b1000_0010, 4 words → targets 1,7,1,7; in_ready stays 1 throughout.
- Backpressure and freeze: word held on ch3 with out_ready[3]=0 for 5 cycles, ch_en cleared to 0 in cycle 2 → out_valid=8'h08 stays stable and in_ready=0. Then raise out_ready[3] → delivered, busy=0, further words stall (no enabled channel).
- Fixed mode: cfg_mode=1, cfg_sel=5, ch_en=8'h20, 3 words → out_valid=8'h20 each time and ptr unchanged. Then ch_en=8'hDF → in_ready=0.
- Counter wrap: preload by streaming 65536 words → xfer_cnt returns to 0 exactly on delivery 65536.
